// File: rtl/ram_port_arb_if.sv
// Bus bundle between the two requesters, the arbiter and the shared RAM.
//   req0/1, lock0/1, we0/1, addr0/1, wdata0/1 : requester side, into arbiter
//   gnt0/1, rvalid0/1, rdata                  : arbiter responses to requesters
//   ram_addr, ram_wdata, ram_write            : arbiter to RAM
//   ram_rdata                                 : RAM to arbiter
// slave modport = arbiter view, master modport = requesters + RAM view.
interface ram_port_arb_if #(
  parameter int AW = 18,
  parameter int DW = 32
);
  logic          req0, req1;
  logic          lock0, lock1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_write;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  ram_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
    output ram_addr, ram_wdata, ram_write
  );

  modport master (
    output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
    output ram_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
    input  ram_addr, ram_wdata, ram_write
  );
endinterface

// File: rtl/ram_port_arb.sv
// Two-requester arbiter in front of one single-port synchronous RAM.
// Round-robin on contention, optional burst lock per requester, and a bounded
// lock length so a locking requester cannot starve the other one.
// Ports:
//   hclk    : clock, rising edge
//   hresetn : asynchronous active-low reset
//   bus     : ram_port_arb_if.slave (requests, grants, read returns, RAM side)
// Grants are combinational (the access happens in the grant cycle); rvalidN is
// registered and marks the RAM read data of port N's read granted last cycle.
module ram_port_arb #(
  parameter int AW       = 18,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic        hclk,
  input  logic        hresetn,
  ram_port_arb_if.slave bus
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_e;

  state_e        state_q, state_d;
  logic          rr_last_q, rr_last_d;   // port granted most recently
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic          g0, g1;                 // grants before reset gating

  always_comb begin
    g0         = 1'b0;
    g1         = 1'b0;
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          // tie goes to the port that did not win last time
          g0 = rr_last_q;
          g1 = ~rr_last_q;
        end else begin
          g0 = bus.req0;
          g1 = bus.req1;
        end
        if (g0) begin
          rr_last_d = 1'b0;
          if (bus.lock0) begin
            state_d    = LOCK0;
            lock_cnt_d = CW'(1);
          end
        end else if (g1) begin
          rr_last_d = 1'b1;
          if (bus.lock1) begin
            state_d    = LOCK1;
            lock_cnt_d = CW'(1);
          end
        end
      end
      LOCK0: begin
        if (bus.req1 && lock_cnt_q == CNT_MAX) begin
          // lock budget spent while port1 waits: hand this cycle to port1
          g1         = 1'b1;
          state_d    = IDLE;
          rr_last_d  = 1'b1;
          lock_cnt_d = '0;
        end else if (bus.req0) begin
          g0        = 1'b1;
          rr_last_d = 1'b0;
          if (bus.lock0) begin
            // only time spent with the other port waiting counts against the lock
            if (bus.req1 && lock_cnt_q != CNT_MAX) lock_cnt_d = lock_cnt_q + CW'(1);
          end else begin
            state_d    = IDLE;
            lock_cnt_d = '0;
          end
        end
        // no req0: burst busy cycle, hold everything
      end
      LOCK1: begin
        if (bus.req0 && lock_cnt_q == CNT_MAX) begin
          g0         = 1'b1;
          state_d    = IDLE;
          rr_last_d  = 1'b0;
          lock_cnt_d = '0;
        end else if (bus.req1) begin
          g1        = 1'b1;
          rr_last_d = 1'b1;
          if (bus.lock1) begin
            if (bus.req0 && lock_cnt_q != CNT_MAX) lock_cnt_d = lock_cnt_q + CW'(1);
          end else begin
            state_d    = IDLE;
            lock_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  // reset gates grants combinationally so nothing reaches the RAM during reset
  assign bus.gnt0 = g0 & hresetn;
  assign bus.gnt1 = g1 & hresetn;

  // idle RAM bus defaults to port0 values with write disabled
  assign bus.ram_addr  = bus.gnt1 ? bus.addr1  : bus.addr0;
  assign bus.ram_wdata = bus.gnt1 ? bus.wdata1 : bus.wdata0;
  assign bus.ram_write = (bus.gnt0 & bus.we0) | (bus.gnt1 & bus.we1);
  assign bus.rdata     = bus.ram_rdata;

  assign rvalid0_d = bus.gnt0 & ~bus.we0;
  assign rvalid1_d = bus.gnt1 & ~bus.we1;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= IDLE;
      rr_last_q  <= 1'b1;
      lock_cnt_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

endmodule
